// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative 16-bit multiply/divide unit for the EX stage
module ex_muldiv_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              div0_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic [ADDR_W-1:0]     rd_cap_q, rd_cap_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [DATA_W-1:0]     a_raw_q, a_raw_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic                  neg_lo_q, neg_lo_d;
    logic                  neg_hi_q, neg_hi_d;
    logic                  div0_pend_q, div0_pend_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [ADDR_W-1:0]     rd_out_q, rd_out_d;
    logic                  div0_q, div0_d;

    // Operand magnitudes; op_i[0]=0 selects the signed variants
    logic              rs_neg, rt_neg;
    logic [DATA_W-1:0] rs_mag, rt_mag;
    assign rs_neg = ~op_i[0] & rs_data_i[DATA_W-1];
    assign rt_neg = ~op_i[0] & rt_data_i[DATA_W-1];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign div_shift = {rem_q, acc_q[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix   = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix   = neg_hi_q ? -rem_q : rem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            rd_cap_q    <= '0;
            b_q         <= '0;
            a_raw_q     <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div0_pend_q <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            rd_out_q    <= '0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            rd_cap_q    <= rd_cap_d;
            b_q         <= b_d;
            a_raw_q     <= a_raw_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            div0_pend_q <= div0_pend_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            rd_out_q    <= rd_out_d;
            div0_q      <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i && !flush_i) state_d = CALC;
            CALC: begin
                if (flush_i)                               state_d = IDLE;
                else if (cnt_q == CNT_W'(DATA_W - 1))      state_d = FIX;
            end
            FIX:  state_d = flush_i ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        rd_cap_d    = rd_cap_q;
        b_d         = b_q;
        a_raw_d     = a_raw_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        div0_pend_d = div0_pend_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rd_out_d    = rd_out_q;
        div0_d      = div0_q;
        unique case (state_q)
            IDLE: if (start_i && !flush_i) begin
                cnt_d       = '0;
                is_div_d    = op_i[1];
                rd_cap_d    = rd_addr_i;
                a_raw_d     = rs_data_i;
                rem_d       = '0;
                neg_lo_d    = rs_neg ^ rt_neg;
                neg_hi_d    = op_i[1] & rs_neg;
                div0_pend_d = op_i[1] & (rt_data_i == '0);
                b_d         = op_i[1] ? rt_mag : rs_mag;
                acc_d       = {{DATA_W{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
            end
            CALC: if (!flush_i) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!is_div_q) begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end else if (!div_diff[DATA_W]) begin
                    rem_d                = div_diff[DATA_W-1:0];
                    acc_d[DATA_W-1:0]    = {acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d                = div_shift[DATA_W-1:0];
                    acc_d[DATA_W-1:0]    = {acc_q[DATA_W-2:0], 1'b0};
                end
            end
            FIX: if (!flush_i) begin
                rd_out_d = rd_cap_q;
                if (!is_div_q) begin
                    lo_d   = prod_fix[DATA_W-1:0];
                    hi_d   = prod_fix[2*DATA_W-1:DATA_W];
                    div0_d = 1'b0;
                end else if (div0_pend_q) begin
                    lo_d   = '1;
                    hi_d   = a_raw_q;
                    div0_d = 1'b1;
                end else begin
                    lo_d   = quo_fix;
                    hi_d   = rem_fix;
                    div0_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            IDLE:      busy_o = start_i & ~flush_i;
            CALC, FIX: busy_o = 1'b1;
            DONE:      done_o = 1'b1;
            default:   busy_o = 1'b0;
        endcase
    end

    assign lo_o      = lo_q;
    assign hi_o      = hi_q;
    assign rd_addr_o = rd_out_q;
    assign div0_o    = div0_q;
endmodule
